// File: rtl/ldpc_pkg.sv
// Shared types and default constants for the LDPC iteration controller.
// The default constants match the reference decoder configuration.
package ldpc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int LDPC_ITER_CYCLES = 7;
   localparam int LDPC_MAX_ITERS   = 17;
   localparam int LDPC_ITER_W      = 8;

endpackage

// File: rtl/ldpc_phase_ctr.sv
// Modulo-ITER_CYCLES phase counter with registered phase strobes.
// Each strobe appears the clock after the counter sits on its phase.
module ldpc_phase_ctr
   import ldpc_pkg::*;
#(
   parameter int ITER_CYCLES = LDPC_ITER_CYCLES,
   parameter int VN_PHASE    = 2,
   parameter int CN_PHASE    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic adv,
   output logic vn_hit,
   output logic cn_hit,
   output logic end_of_iter
);

   localparam int CW = $clog2(ITER_CYCLES);
   localparam logic [CW-1:0] LAST  = CW'(ITER_CYCLES - 1);
   localparam logic [CW-1:0] VN_AT = CW'(VN_PHASE);
   localparam logic [CW-1:0] CN_AT = CW'(CN_PHASE);

   logic [CW-1:0] cnt;

   // Advance the phase and flag the phase matches of the advancing cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         vn_hit      <= 1'b0;
         cn_hit      <= 1'b0;
         end_of_iter <= 1'b0;
      end else if (clr) begin
         cnt         <= '0;
         vn_hit      <= 1'b0;
         cn_hit      <= 1'b0;
         end_of_iter <= 1'b0;
      end else begin
         vn_hit      <= adv && (cnt == VN_AT);
         cn_hit      <= adv && (cnt == CN_AT);
         end_of_iter <= adv && (cnt == LAST);
         if (adv) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ldpc_iter_scheduler.sv
// LDPC iteration scheduler: start/done handshake, stall, abort and
// syndrome-based early termination around a phase counter.
module ldpc_iter_scheduler
   import ldpc_pkg::*;
#(
   parameter int ITER_CYCLES  = LDPC_ITER_CYCLES,
   parameter int VN_PHASE     = 2,
   parameter int CN_PHASE     = 4,
   parameter int MAX_ITERS    = LDPC_MAX_ITERS,
   parameter int ITER_W       = LDPC_ITER_W,
   parameter int EARLY_TERM   = 1,
   parameter int STABLE_ITERS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              en,
   input  logic              abort,
   input  logic              syndrome_ok,
   output logic              vn_latch,
   output logic              cn_latch,
   output logic              first_iter,
   output logic [ITER_W-1:0] iter_num,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [ITER_W-1:0] iters_used
);

   if (ITER_CYCLES < 3) begin : g_bad_cycles
      $error("ITER_CYCLES must be at least 3");
   end
   if (VN_PHASE < 0 || VN_PHASE >= CN_PHASE || CN_PHASE >= ITER_CYCLES) begin : g_bad_phase
      $error("need 0 <= VN_PHASE < CN_PHASE < ITER_CYCLES");
   end
   if (MAX_ITERS < 1 || MAX_ITERS >= (1 << ITER_W)) begin : g_bad_iters
      $error("MAX_ITERS must be in 1 .. 2**ITER_W-1");
   end
   if (STABLE_ITERS < 1 || STABLE_ITERS >= (1 << ITER_W)) begin : g_bad_stable
      $error("STABLE_ITERS must be in 1 .. 2**ITER_W-1");
   end
   if (EARLY_TERM != 0 && EARLY_TERM != 1) begin : g_bad_early
      $error("EARLY_TERM must be 0 or 1");
   end

   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITERS - 1);
   localparam logic [ITER_W-1:0] MAX_N     = ITER_W'(MAX_ITERS);
   localparam logic [ITER_W-1:0] STABLE_N  = ITER_W'(STABLE_ITERS);
   localparam logic              EARLY_ON  = (EARLY_TERM != 0);

   state_t            state, state_nx;
   logic [ITER_W-1:0] iter_q, iter_nx;
   logic [ITER_W-1:0] stable_q, stable_nx;
   logic [ITER_W-1:0] used_q, used_nx;
   logic [ITER_W-1:0] bump;
   logic              conv_q, conv_nx;
   logic              clr, adv, eoi;

   assign bump = stable_q + 1'b1;

   ldpc_phase_ctr #(
      .ITER_CYCLES(ITER_CYCLES),
      .VN_PHASE   (VN_PHASE),
      .CN_PHASE   (CN_PHASE)
   ) u_phase (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .adv        (adv),
      .vn_hit     (vn_latch),
      .cn_hit     (cn_latch),
      .end_of_iter(eoi)
   );

   // Next state; the counter is held on the finishing cycle so no strobe leaks.
   always_comb begin
      state_nx  = state;
      iter_nx   = iter_q;
      stable_nx = stable_q;
      used_nx   = used_q;
      conv_nx   = conv_q;
      clr       = 1'b0;
      adv       = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nx  = ST_RUN;
               iter_nx   = '0;
               stable_nx = '0;
               used_nx   = '0;
               conv_nx   = 1'b0;
               clr       = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nx  = ST_IDLE;
               iter_nx   = '0;
               stable_nx = '0;
               clr       = 1'b1;
            end else begin
               adv = en;
               if (eoi) begin
                  if (EARLY_ON && syndrome_ok) begin
                     stable_nx = bump;
                  end else if (!syndrome_ok) begin
                     stable_nx = '0;
                  end
                  if (EARLY_ON && syndrome_ok && bump == STABLE_N) begin
                     state_nx = ST_DONE;
                     conv_nx  = 1'b1;
                     used_nx  = iter_q + 1'b1;
                     adv      = 1'b0;
                  end else if (iter_q == LAST_ITER) begin
                     state_nx = ST_DONE;
                     conv_nx  = syndrome_ok;
                     used_nx  = MAX_N;
                     adv      = 1'b0;
                  end else begin
                     iter_nx = iter_q + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Controller state and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         iter_q   <= '0;
         stable_q <= '0;
         used_q   <= '0;
         conv_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         iter_q   <= iter_nx;
         stable_q <= stable_nx;
         used_q   <= used_nx;
         conv_q   <= conv_nx;
      end
   end

   assign busy       = (state == ST_RUN);
   assign done       = (state == ST_DONE);
   assign first_iter = busy && (iter_q == '0);
   assign iter_num   = iter_q;
   assign iters_used = used_q;
   assign converged  = conv_q;

endmodule

// File: tb/tb_ldpc_iter_scheduler.sv
// Scoreboard bench for ldpc_iter_scheduler: two parameterisations,
// directed scenarios plus randomized syndrome and stall patterns.
module tb_ldpc_iter_scheduler;

   localparam int IC = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] start = '0, en = '0, abort = '0, syn = '0;
   logic [1:0] vn, cn, fi, busy, done, conv;
   logic [7:0] iter [2];
   logic [7:0] used [2];

   typedef struct {
      bit aborted;
      int used;
      bit conv;
      int cycles;
      int vn2t;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ldpc_iter_scheduler #(.STABLE_ITERS(2)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .en(en[0]),
      .abort(abort[0]), .syndrome_ok(syn[0]),
      .vn_latch(vn[0]), .cn_latch(cn[0]), .first_iter(fi[0]),
      .iter_num(iter[0]), .busy(busy[0]), .done(done[0]),
      .converged(conv[0]), .iters_used(used[0])
   );

   ldpc_iter_scheduler #(.MAX_ITERS(4), .EARLY_TERM(0)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .en(en[1]),
      .abort(abort[1]), .syndrome_ok(syn[1]),
      .vn_latch(vn[1]), .cn_latch(cn[1]), .first_iter(fi[1]),
      .iter_num(iter[1]), .busy(busy[1]), .done(done[1]),
      .converged(conv[1]), .iters_used(used[1])
   );

   function automatic int pmax(input int d);
      return (d == 0) ? 17 : 4;
   endfunction
   function automatic bit pearly(input int d);
      return d == 0;
   endfunction
   function automatic int pstable(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Iteration-level reference: pat[k] is the syndrome seen at the end of iteration k.
   function automatic void model(input int d, input logic [31:0] pat,
                                 output int u, output bit c);
      int st = 0;
      u = pmax(d);
      c = 1'b0;
      for (int k = 0; k < pmax(d); k++) begin
         if (pat[k] && pearly(d)) begin
            st++;
            if (st == pstable(d)) begin
               u = k + 1;
               c = 1'b1;
               return;
            end
         end else if (!pat[k]) begin
            st = 0;
         end
         if (k == pmax(d) - 1) c = pat[k];
      end
   endfunction

   // Monitor state, one slot per DUT.
   int         t [2], vnc [2], cnc [2], vn1 [2], cn1 [2], vn2 [2], steps [2];
   bit         badstep [2], ovl [2], pb [2], pd [2];
   logic [7:0] lastit [2];
   exp_t       e_m;
   bit         have_m;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (busy[d] && !pb[d]) begin
            t[d] = 0; vnc[d] = 0; cnc[d] = 0; steps[d] = 0;
            vn1[d] = -1; cn1[d] = -1; vn2[d] = -1;
            badstep[d] = 0; ovl[d] = 0; lastit[d] = iter[d];
         end else begin
            t[d]++;
         end
         if (busy[d]) begin
            if (vn[d]) begin
               vnc[d]++;
               if (vnc[d] == 1) vn1[d] = t[d];
               if (vnc[d] == 2) vn2[d] = t[d];
            end
            if (cn[d]) begin
               cnc[d]++;
               if (cnc[d] == 1) cn1[d] = t[d];
            end
            if (vn[d] && cn[d]) ovl[d] = 1;
            if (iter[d] != lastit[d]) begin
               if (int'(iter[d]) != int'(lastit[d]) + 1) badstep[d] = 1;
               steps[d]++;
               lastit[d] = iter[d];
            end
         end
         if (done[d]) chk("quiet_in_done", int'({vn[d], cn[d]}), 0);
         if ((done[d] && !pd[d]) || (!busy[d] && pb[d] && !done[d])) begin
            have_m = 0;
            if (d == 0 && q0.size() > 0) begin e_m = q0.pop_front(); have_m = 1; end
            if (d == 1 && q1.size() > 0) begin e_m = q1.pop_front(); have_m = 1; end
            if (!have_m) begin
               checks++; errors++;
               $display("FAIL scoreboard_empty: dut%0d ended a run with nothing expected", d);
            end else if (!done[d]) begin
               chk("run_aborted", int'(e_m.aborted), 1);
            end else begin
               chk("done_not_abort", int'(e_m.aborted), 0);
               if (!e_m.aborted) begin
                  chk("converged", int'(conv[d]), int'(e_m.conv));
                  chk("iters_used", int'(used[d]), e_m.used);
                  chk("done_latency", t[d], e_m.cycles);
                  chk("vn_count", vnc[d], e_m.used);
                  chk("cn_count", cnc[d], e_m.used);
                  chk("first_vn_time", vn1[d], 3);
                  chk("first_cn_time", cn1[d], 5);
                  if (e_m.used > 1) chk("second_vn_time", vn2[d], e_m.vn2t);
                  chk("iter_steps", steps[d], e_m.used - 1);
                  chk("iter_seq_gap", int'(badstep[d]), 0);
                  chk("strobe_overlap", int'(ovl[d]), 0);
               end
            end
         end
         pb[d] = busy[d];
         pd[d] = done[d];
      end
   end

   // One decode: sp/sn = stall position/length, kp = kill position (abort or reset).
   task automatic run(input int d, input logic [31:0] pat, input int sp, input int sn,
                      input int kp, input bit krst, input bit keep);
      int   u, p, stl, guard;
      bit   c;
      exp_t e;
      model(d, pat, u, c);
      e.aborted = (kp >= 0);
      e.used    = u;
      e.conv    = c;
      e.cycles  = IC * u + 1 + ((sp >= 0) ? sn : 0);
      e.vn2t    = 10 + ((sp >= 0 && sp <= 9) ? sn : 0);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      @(negedge clk);
      start[d] = 1'b1; en[d] = 1'b1; syn[d] = 1'b0;
      @(negedge clk);
      start[d] = keep;
      chk("start_iter_num", int'(iter[d]), 0);
      chk("start_first_iter", int'(fi[d]), 1);
      p = 0; stl = 0; guard = 0;
      while (busy[d] && guard < 2000) begin
         syn[d] = (p >= 4) ? pat[(p + 3) / IC - 1] : 1'b0;
         en[d]  = !(p == sp && stl < sn);
         if (p == kp && krst) begin
            #2 rst = 1'b1;
            #1 chk("reset_outputs",
                   int'({vn[d], cn[d], fi[d], busy[d], done[d], conv[d], iter[d], used[d]}), 0);
            @(negedge clk);
            rst = 1'b0;
         end else begin
            abort[d] = (p == kp);
            @(posedge clk);
            if (en[d]) p++; else stl++;
            guard++;
            @(negedge clk);
         end
      end
      abort[d] = 1'b0;
      en[d]    = 1'b1;
      if (guard >= 2000) begin
         checks++; errors++;
         $display("FAIL run_timeout: dut%0d still busy after %0d cycles", d, guard);
      end
      if (kp >= 0) chk("abort_no_done", int'(done[d]), 0);
      if (keep) begin
         e.aborted = 1;
         if (d == 0) q0.push_back(e); else q1.push_back(e);
         @(negedge clk);
         chk("restart_busy", int'(busy[d]), 1);
         chk("restart_done", int'(done[d]), 0);
         start[d] = 1'b0;
         abort[d] = 1'b1;
         @(negedge clk);
         abort[d] = 1'b0;
         chk("abort_to_idle", int'(busy[d]), 0);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_state",
             int'({vn[d], cn[d], fi[d], busy[d], done[d], conv[d], iter[d], used[d]}), 0);
      end
      rst = 1'b0;
      run(0, 32'h0, -1, 0, -1, 0, 0);
      run(0, 32'hFFFF_FFF8, -1, 0, -1, 0, 0);
      run(0, 32'h0, 9, 3, -1, 0, 0);
      run(0, 32'h0, -1, 0, IC * 17 - 1, 0, 0);
      run(0, 32'h0, -1, 0, -1, 0, 0);
      run(0, 32'h0, -1, 0, IC * 5 + 3, 1, 0);
      run(0, 32'h0, -1, 0, -1, 0, 0);
      run(1, 32'hFFFF_FFFF, -1, 0, -1, 0, 1);
      for (int i = 0; i < 8; i++) begin
         int          d, u, sp, sn;
         bit          c;
         logic [31:0] pt;
         d  = i % 2;
         pt = (d == 0) ? ($urandom | $urandom) : $urandom;
         model(d, pt, u, c);
         if ($urandom_range(0, 2) == 0) begin
            sp = -1; sn = 0;
         end else begin
            sp = $urandom_range(5, IC * u - 1);
            sn = $urandom_range(1, 4);
         end
         run(d, pt, sp, sn, -1, 0, 0);
      end
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", q0.size() + q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ldpc_iter_scheduler.md
Name: ldpc_iter_scheduler

Overview:
Parametrised iteration controller for the LDPC decoder datapath. It sequences decoding iterations and emits one-cycle latch strobes for the VNPU (Qij) and CNPU (Rji) registers. It adds what the fixed-length controller lacked: a start/done handshake, stall support, abort, and early termination once the syndrome check passes for a configurable number of consecutive iterations. It sits between system control and the VNPU/CNPU/Decision Unit register stages.

Parameters:
ITER_CYCLES, 7, clocks per iteration (>= 3)
VN_PHASE, 2, cycle_cnt value at which vn_latch fires
CN_PHASE, 4, cycle_cnt value at which cn_latch fires (VN_PHASE < CN_PHASE < ITER_CYCLES)
MAX_ITERS, 17, hard iteration limit (>= 1)
ITER_W, 8, width of iteration counters (MAX_ITERS < 2**ITER_W)
EARLY_TERM, 1, 1 enables syndrome-based early stop
STABLE_ITERS, 1, consecutive syndrome_ok iterations required to stop early (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a decode (honoured in IDLE or DONE)
en  in  1  advance enable; low = stall
abort  in  1  cancel a run in progress
syndrome_ok  in  1  all parity checks satisfied by current hard decision
vn_latch  out  1  one-cycle strobe: capture VNPU output
cn_latch  out  1  one-cycle strobe: capture CNPU output
first_iter  out  1  high while iter_num == 0 in RUN (selects zero Rji)
iter_num  out  ITER_W  current iteration index
busy  out  1  high in RUN
done  out  1  high in DONE
converged  out  1  valid with done: stopped with syndrome_ok
iters_used  out  ITER_W  valid with done: iterations completed

Behaviour:
- Reset (async, active-high): state=IDLE; cycle_cnt, iter_num, stable_cnt, iters_used = 0; all 1-bit outputs = 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: start=1 -> RUN next cycle with cycle_cnt=0, iter_num=0, stable_cnt=0, converged=0.
- RUN, en=1:
  - cycle_cnt increments and wraps from ITER_CYCLES-1 to 0.
  - vn_latch is high exactly for the cycle where cycle_cnt==VN_PHASE; cn_latch likewise for CN_PHASE.
  - Strobes never overlap.
- RUN, en=0: cycle_cnt and iter_num are frozen; vn_latch and cn_latch are 0 that cycle; a strobe resumes when en returns.
- End of iteration (cycle_cnt==ITER_CYCLES-1 and en=1): syndrome_ok is sampled.
  - EARLY_TERM=1 and syndrome_ok=1: stable_cnt+1. On reaching STABLE_ITERS -> DONE, converged=1, iters_used=iter_num+1.
  - syndrome_ok=0: stable_cnt=0.
  - Otherwise, if iter_num==MAX_ITERS-1 -> DONE, converged=syndrome_ok, iters_used=MAX_ITERS.
  - Otherwise iter_num+1.
- abort in RUN -> IDLE next cycle; done is not asserted; iter_num is cleared. abort takes priority over end-of-iteration and early stop in the same cycle. abort is ignored in IDLE and DONE.
- start while RUN is ignored.
- DONE: done, converged and iters_used hold until start=1, which re-enters RUN directly (done=0 next cycle). en is irrelevant in DONE.
- first_iter = busy and iter_num==0.
- Reset mid-run returns to IDLE immediately; no done and no strobes.
- Latency: first vn_latch appears VN_PHASE+1 clocks after start is sampled (no stalls). With no early stop, done rises MAX_ITERS*ITER_CYCLES+1 clocks after start.

Decomposition:
- Shared package ldpc_pkg: state enum (IDLE/RUN/DONE); default constants LDPC_ITER_CYCLES=7, LDPC_MAX_ITERS=17, LDPC_ITER_W=8.
- Sub-module ldpc_phase_ctr: modulo-ITER_CYCLES counter with enable, producing phase-match strobes and end_of_iter. The FSM, iteration counter and stable_cnt stay in the top block.
- Parameter legality is checked with elaboration-time assertions.

Test Plan:
- Defaults, en=1, syndrome_ok=0, single start pulse -> 17 vn_latch and 17 cn_latch pulses spaced 7 clocks apart, cn_latch 2 clocks after each vn_latch; done after 120 clocks; iters_used=17, converged=0.
- syndrome_ok=1 from iteration 3 onward, STABLE_ITERS=2 -> done at end of iteration 4; iters_used=5, converged=1; no strobes after done.
- en low for 3 clocks around cycle_cnt==2 of iteration 1 -> vn_latch delayed exactly 3 clocks; total run 123 clocks; iter_num sequence unbroken.
- abort asserted in the same cycle as the final end-of-iteration -> IDLE, done stays 0; a following start rerun gives iter_num=0 and first_iter=1.
- rst pulsed mid-iteration 5 -> all outputs 0 asynchronously; FSM in IDLE; a new start behaves as scenario 1.
- EARLY_TERM=0, syndrome_ok=1 throughout, MAX_ITERS=4 -> done after 4 iterations, converged=1, iters_used=4; start held high in DONE restarts RUN on the next clock.
